// File: rtl/up_param.sv
// up_param: two-phase (FETCH/EXEC) accumulator processor core with parametrised data width.
// Define UPP_MEM_WAIT_EN to let memory opcodes stall in WAIT until mem_ack.
module up_param #(
    parameter int          DATA_W   = 4,
    parameter int unsigned RESET_PC = 0,
    localparam int         ADDR_W   = 2*DATA_W+4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W-1:0]   pushbuttons,
    output logic [ADDR_W-1:0]   prog_addr,
    input  logic [DATA_W+3:0]   prog_data,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_re,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic [1:0]          phase,
    output logic [3:0]          instr,
    output logic [DATA_W-1:0]   oprnd,
    output logic [DATA_W-1:0]   accu,
    output logic [DATA_W-1:0]   out_port,
    output logic                c_flag,
    output logic                z_flag,
    output logic [ADDR_W-1:0]   pc,
    output logic                instr_done
);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        WAIT  = 2'b10
    } phase_t;

    phase_t            state;
    logic              active;
    logic              complete;
    logic              is_mem;
    logic              is_jump;
    logic              rd_mem;
    logic              taken;
    logic              upd_flags;
    logic              wr_accu;
    logic [DATA_W:0]   alu;

    assign active    = (state == EXEC) || (state == WAIT);
    assign phase     = state;
    assign prog_addr = pc;
    // In EXEC/WAIT pc already points at the second word, so prog_data is the address low part.
    assign mem_addr  = {oprnd, prog_data};
    assign mem_wdata = accu;
    assign mem_re    = active && rd_mem;
    assign mem_we    = active && (instr == 4'h7);

`ifdef UPP_MEM_WAIT_EN
    assign complete = ((state == EXEC) && (!is_mem || mem_ack)) ||
                      ((state == WAIT) && mem_ack);
`else
    // Memory is treated as combinational: mem_ack is read but has no effect.
    assign complete = active | (mem_ack & 1'b0);
`endif

    assign instr_done = complete;

    always_comb begin
        is_mem    = 1'b0;
        is_jump   = 1'b0;
        rd_mem    = 1'b0;
        taken     = 1'b0;
        upd_flags = 1'b0;
        wr_accu   = 1'b0;
        alu       = '0;
        case (instr)
            4'h0: begin is_jump = 1'b1; taken = c_flag;  end
            4'h1: begin is_jump = 1'b1; taken = !c_flag; end
            4'h8: begin is_jump = 1'b1; taken = z_flag;  end
            4'h9: begin is_jump = 1'b1; taken = !z_flag; end
            4'hC: begin is_jump = 1'b1; taken = 1'b1;    end
            4'h2: begin
                alu = {1'b0, accu} - {1'b0, oprnd};
                upd_flags = 1'b1;
            end
            4'h3: begin
                is_mem = 1'b1; rd_mem = 1'b1;
                alu = {1'b0, accu} - {1'b0, mem_rdata};
                upd_flags = 1'b1;
            end
            4'h4: begin alu = {1'b0, oprnd};       upd_flags = 1'b1; wr_accu = 1'b1; end
            4'h5: begin alu = {1'b0, pushbuttons}; upd_flags = 1'b1; wr_accu = 1'b1; end
            4'h6: begin
                is_mem = 1'b1; rd_mem = 1'b1;
                alu = {1'b0, mem_rdata};
                upd_flags = 1'b1; wr_accu = 1'b1;
            end
            4'h7: is_mem = 1'b1;
            4'hA: begin
                alu = {1'b0, accu} + {1'b0, oprnd};
                upd_flags = 1'b1; wr_accu = 1'b1;
            end
            4'hB: begin
                is_mem = 1'b1; rd_mem = 1'b1;
                alu = {1'b0, accu} + {1'b0, mem_rdata};
                upd_flags = 1'b1; wr_accu = 1'b1;
            end
            4'hE: begin alu = {1'b0, ~(accu & oprnd)}; upd_flags = 1'b1; wr_accu = 1'b1; end
            4'hF: begin
                is_mem = 1'b1; rd_mem = 1'b1;
                alu = {1'b0, ~(accu & mem_rdata)};
                upd_flags = 1'b1; wr_accu = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= ADDR_W'(RESET_PC);
            instr    <= '0;
            oprnd    <= '0;
            accu     <= '0;
            out_port <= '0;
            c_flag   <= 1'b0;
            z_flag   <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    instr <= prog_data[DATA_W+3:DATA_W];
                    oprnd <= prog_data[DATA_W-1:0];
                    pc    <= pc + 1'b1;
                    state <= EXEC;
                end
                EXEC, WAIT: begin
                    if (complete) begin
                        state <= FETCH;
                        if (wr_accu)
                            accu <= alu[DATA_W-1:0];
                        if (upd_flags) begin
                            c_flag <= alu[DATA_W];
                            z_flag <= (alu[DATA_W-1:0] == '0);
                        end
                        if (instr == 4'hD)
                            out_port <= accu;
                        if (taken)
                            pc <= mem_addr;
                        else if (is_mem || is_jump)
                            pc <= pc + 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_up_param.sv
// Scoreboard bench for up_param: directed program in a ROM model, expected retire results queued up front.
// Wait-state checks are included when UPP_MEM_WAIT_EN is defined.
module tb_up_param;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  pushbuttons;
    logic [11:0] prog_addr;
    logic [7:0]  prog_data;
    logic [11:0] mem_addr;
    logic        mem_re, mem_we;
    logic [3:0]  mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [1:0]  phase;
    logic [3:0]  instr, oprnd, accu, out_port;
    logic        c_flag, z_flag;
    logic [11:0] pc;
    logic        instr_done;

    logic [7:0]  rom [4096];
    logic [3:0]  ram [4096];

    always #5 clock = ~clock;

    assign prog_data = rom[prog_addr];
    assign mem_rdata = ram[mem_addr];
    always @(posedge clock)
        if (mem_we && mem_ack) ram[mem_addr] <= mem_wdata;

    up_param #(.DATA_W(4), .RESET_PC(32'h010)) dut (
        .clock(clock), .reset(reset), .pushbuttons(pushbuttons),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .phase(phase), .instr(instr), .oprnd(oprnd), .accu(accu),
        .out_port(out_port), .c_flag(c_flag), .z_flag(z_flag),
        .pc(pc), .instr_done(instr_done)
    );

    // 8-bit build: only the wrap-to-zero add is exercised.
    logic [7:0]  pb8, rdata8, wdata8, oprnd8, accu8, out8;
    logic [19:0] paddr8, maddr8, pc8;
    logic [11:0] pdata8;
    logic [11:0] rom8 [4];
    logic        re8, we8, c8, z8, done8;
    logic [1:0]  phase8;
    logic [3:0]  instr8;

    assign pb8     = '0;
    assign rdata8  = '0;
    assign pdata8  = rom8[paddr8[1:0]];

    up_param #(.DATA_W(8), .RESET_PC(32'h0)) dut8 (
        .clock(clock), .reset(reset), .pushbuttons(pb8),
        .prog_addr(paddr8), .prog_data(pdata8),
        .mem_addr(maddr8), .mem_re(re8), .mem_we(we8),
        .mem_wdata(wdata8), .mem_rdata(rdata8), .mem_ack(1'b1),
        .phase(phase8), .instr(instr8), .oprnd(oprnd8), .accu(accu8),
        .out_port(out8), .c_flag(c8), .z_flag(z8),
        .pc(pc8), .instr_done(done8)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic        re, we;
        logic [11:0] addr;
        logic [3:0]  accu;
        logic        c, z;
        logic [11:0] pc;
        logic [3:0]  outp;
    } exp_t;

    typedef struct packed {
        logic [7:0] accu;
        logic       c, z;
    } exp8_t;

    exp_t  q[$];
    exp8_t q8[$];
    exp_t  e;
    exp8_t e8;
    int    tests = 0;
    int    fails = 0;
    bit    chk_en = 1'b0;
    bit    chk_en8 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] op, input logic re, input logic we,
                        input logic [11:0] addr, input logic [3:0] acc,
                        input logic c, input logic z, input logic [11:0] pcv,
                        input logic [3:0] o);
        q.push_back('{op, re, we, addr, acc, c, z, pcv, o});
    endtask

    task automatic wait_fetch(input logic [11:0] a);
        bit hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clock);
            hit = (phase == 2'b00) && (prog_addr == a);
        end
        if (!hit) begin
            tests++; fails++;
            $display("FAIL wait_fetch_%0h: timeout, phase %0b prog_addr %0h", a, phase, prog_addr);
        end
    endtask

    // Monitor: retire-cycle strobes, then architectural state one cycle later.
    always begin
        @(negedge clock);
        if (chk_en && instr_done) begin
            if (q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_retire: instr %0h at pc %0h with empty scoreboard", instr, pc);
            end else begin
                e = q.pop_front();
                chk("retire_op", instr, e.op);
                chk("strobes", {mem_re, mem_we}, {e.re, e.we});
                if (e.re || e.we) chk("mem_addr", mem_addr, e.addr);
                if (e.we) chk("mem_wdata", mem_wdata, e.accu);
                @(negedge clock);
                chk("accu", accu, e.accu);
                chk("flags_cz", {c_flag, z_flag}, {e.c, e.z});
                chk("pc", pc, e.pc);
                chk("out_port", out_port, e.outp);
            end
        end
    end

    always begin
        @(negedge clock);
        if (chk_en8 && done8 && q8.size() != 0) begin
            e8 = q8.pop_front();
            @(negedge clock);
            chk("w8_accu", accu8, e8.accu);
            chk("w8_flags_cz", {c8, z8}, {e8.c, e8.z});
        end
    end

    initial begin
        logic [19:0] img[$];
        img = '{20'h010_47, 20'h011_AA, 20'h012_21, 20'h013_73, 20'h014_45,
                20'h015_40, 20'h016_63, 20'h017_45, 20'h018_82, 20'h019_10,
                20'h01A_21, 20'h01B_82, 20'h01C_10,
                20'h210_D0, 20'h211_50, 20'h212_D0, 20'h213_E3, 20'h214_B3,
                20'h215_45, 20'h216_0F, 20'h217_FF,
                20'hFFF_45, 20'h000_CF, 20'h001_FE, 20'hFFE_C0,
                20'h045_33, 20'h046_45, 20'h047_27, 20'h048_F3, 20'h049_45,
                20'h04A_90, 20'h04B_60,
                20'h060_63, 20'h061_45, 20'h062_49, 20'h063_63, 20'h064_45,
                20'h065_C0, 20'h066_65};
        for (int i = 0; i < 4096; i++) begin
            rom[i] = 8'h40;
            ram[i] = 4'h0;
        end
        foreach (img[i]) rom[img[i][19:8]] = img[i][7:0];
        rom8[0] = 12'h4FF; rom8[1] = 12'hA01; rom8[2] = 12'hC00; rom8[3] = 12'h002;

        //   op     re    we    addr     accu  c     z     pc      out
        push(4'h4, 1'b0, 1'b0, 12'h000, 4'h7, 1'b0, 1'b0, 12'h011, 4'h0);
        push(4'hA, 1'b0, 1'b0, 12'h000, 4'h1, 1'b1, 1'b0, 12'h012, 4'h0);
        push(4'h2, 1'b0, 1'b0, 12'h000, 4'h1, 1'b0, 1'b1, 12'h013, 4'h0);
        push(4'h7, 1'b0, 1'b1, 12'h345, 4'h1, 1'b0, 1'b1, 12'h015, 4'h0);
        push(4'h4, 1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 1'b1, 12'h016, 4'h0);
        push(4'h6, 1'b1, 1'b0, 12'h345, 4'h1, 1'b0, 1'b0, 12'h018, 4'h0);
        push(4'h8, 1'b0, 1'b0, 12'h000, 4'h1, 1'b0, 1'b0, 12'h01A, 4'h0);
        push(4'h2, 1'b0, 1'b0, 12'h000, 4'h1, 1'b0, 1'b1, 12'h01B, 4'h0);
        push(4'h8, 1'b0, 1'b0, 12'h000, 4'h1, 1'b0, 1'b1, 12'h210, 4'h0);
        push(4'hD, 1'b0, 1'b0, 12'h000, 4'h1, 1'b0, 1'b1, 12'h211, 4'h1);
        push(4'h5, 1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 1'b1, 12'h212, 4'h1);
        push(4'hD, 1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 1'b1, 12'h213, 4'h0);
        push(4'hE, 1'b0, 1'b0, 12'h000, 4'hF, 1'b0, 1'b0, 12'h214, 4'h0);
        push(4'hB, 1'b1, 1'b0, 12'h345, 4'h0, 1'b1, 1'b1, 12'h216, 4'h0);
        push(4'h0, 1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 1'b1, 12'hFFF, 4'h0);
        push(4'h4, 1'b0, 1'b0, 12'h000, 4'h5, 1'b0, 1'b0, 12'h000, 4'h0);
        push(4'hC, 1'b0, 1'b0, 12'h000, 4'h5, 1'b0, 1'b0, 12'hFFE, 4'h0);
        push(4'hC, 1'b0, 1'b0, 12'h000, 4'h5, 1'b0, 1'b0, 12'h045, 4'h0);
        push(4'h3, 1'b1, 1'b0, 12'h345, 4'h5, 1'b0, 1'b0, 12'h047, 4'h0);
        push(4'h2, 1'b0, 1'b0, 12'h000, 4'h5, 1'b1, 1'b0, 12'h048, 4'h0);
        push(4'hF, 1'b1, 1'b0, 12'h345, 4'hE, 1'b0, 1'b0, 12'h04A, 4'h0);
        push(4'h9, 1'b0, 1'b0, 12'h000, 4'hE, 1'b0, 1'b0, 12'h060, 4'h0);
        push(4'h6, 1'b1, 1'b0, 12'h345, 4'h1, 1'b0, 1'b0, 12'h062, 4'h0);
        push(4'h4, 1'b0, 1'b0, 12'h000, 4'h9, 1'b0, 1'b0, 12'h063, 4'h0);
`ifndef UPP_MEM_WAIT_EN
        push(4'h6, 1'b1, 1'b0, 12'h345, 4'h1, 1'b0, 1'b0, 12'h065, 4'h0);
        push(4'hC, 1'b0, 1'b0, 12'h000, 4'h1, 1'b0, 1'b0, 12'h065, 4'h0);
`endif
        q8.push_back('{8'hFF, 1'b0, 1'b0});
        q8.push_back('{8'h00, 1'b1, 1'b1});
        q8.push_back('{8'h00, 1'b1, 1'b1});

        mem_ack     = 1'b1;
        pushbuttons = 4'h0;
        reset       = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_pc", pc, 12'h010);
        chk("reset_phase", phase, 2'b00);
        chk("reset_accu", accu, 4'h0);
        chk("reset_flags", {c_flag, z_flag}, 2'b00);
        chk("reset_out", out_port, 4'h0);
        chk("reset_strobes", {mem_re, mem_we, instr_done}, 3'b000);

        @(posedge clock); #1;
        reset   = 1'b0;
        chk_en  = 1'b1;
        chk_en8 = 1'b1;
        @(negedge clock);
        chk("first_fetch_addr", prog_addr, 12'h010);

`ifdef UPP_MEM_WAIT_EN
        wait_fetch(12'h060);
        @(posedge clock); #1 mem_ack = 1'b0;
        @(negedge clock);
        chk("exec_stall_no_done", {phase, instr_done}, {2'b01, 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("wait_phase", phase, 2'b10);
            chk("wait_strobes", {mem_re, mem_we, instr_done}, 3'b100);
            chk("wait_addr", mem_addr, 12'h345);
        end
        @(posedge clock); #1 mem_ack = 1'b1;
        wait_fetch(12'h063);
        @(posedge clock); #1 mem_ack = 1'b0;
`endif

        for (int i = 0; i < 400 && (q.size() != 0 || q8.size() != 0); i++)
            @(posedge clock);
        chk_en  = 1'b0;
        chk_en8 = 1'b0;

`ifdef UPP_MEM_WAIT_EN
        for (int i = 0; i < 20 && phase != 2'b10; i++) @(negedge clock);
        @(negedge clock);
        chk("abort_in_wait", {phase, mem_re}, {2'b10, 1'b1});
`endif
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("late_reset_phase_pc", {phase, pc}, {2'b00, 12'h010});
        chk("late_reset_accu", accu, 4'h0);
        chk("late_reset_strobes", {mem_re, mem_we, instr_done}, 3'b000);
        chk("scoreboard_drained", q.size(), 0);
        chk("scoreboard8_drained", q8.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
